// File: rtl/core_pkg.sv
// Shared definitions for the core data memory.
//   SIZE_*       access-size encodings carried on i_data_mask
//   mem_state_e  responder FSM states
//   mem_rsp_t    response payload (read data + error)
//   byte_en()    byte-lane enables from access size and addr[1:0]
package core_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } mem_rsp_t;

  // Alignment is not checked here; callers gate with their own error flag.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  byte_en = 4'b0001 << lane;
      SIZE_H:  byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Combinational lane alignment for the data memory.
//   size, lane   access size and byte offset (addr[1:0])
//   wr_data      right-justified store data
//   rd_word      full addressed memory word
//   be           byte enables (zero on a faulting access)
//   wr_word      store data replicated into its lanes
//   rd_data      right-justified load data, upper bits zeroed
//   misalign     misaligned access or reserved size
module core_mem_align
  import core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    misalign = (size == SIZE_H && lane[0]) ||
               (size == SIZE_W && lane != 2'b00) ||
               (size == 2'b11);
    be       = misalign ? 4'b0000 : byte_en(size, lane);

    // Replication puts the data in every lane; be picks the real ones.
    case (size)
      SIZE_B:  wr_word = {4{wr_data[7:0]}};
      SIZE_H:  wr_word = {2{wr_data[15:0]}};
      default: wr_word = wr_data;
    endcase

    shifted = rd_word >> {lane, 3'b000};
    case (size)
      SIZE_B:  rd_data = {24'h0, shifted[7:0]};
      SIZE_H:  rd_data = {16'h0, shifted[15:0]};
      default: rd_data = shifted;
    endcase
    if (misalign) rd_data = '0;
  end

endmodule

// File: rtl/core_data_mem.sv
// Word-organised data memory responding on the core's req/ack data port.
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_data_req          request valid (fields held until accepted)
//   i_data_addr         byte address; upper bits alias
//   i_data_wr_en        1 = store, 0 = load
//   i_data_mask         access size (00 byte, 01 half, 10 word)
//   i_data_wr_data      right-justified store data
//   o_data_ack          one-cycle response pulse, LATENCY cycles after accept
//   o_data_rd_data      right-justified load data (0 for stores/errors)
//   o_data_err          misaligned access or reserved size
module core_data_mem
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic            i_data_wr_en,
  input  logic [1:0]      i_data_mask,
  input  logic [XLEN-1:0] i_data_wr_data,
  output logic            o_data_ack,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic            o_data_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  mem_state_e  state;
  logic [CW-1:0] cnt;
  mem_rsp_t    pend;
  mem_rsp_t    rsp_now;

  logic [AW-1:0] idx;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   wr_word;
  logic [31:0]   rd_data;
  logic          misalign;
  logic          unused_addr;

  assign idx         = i_data_addr[AW+1:2];
  assign unused_addr = ^i_data_addr[XLEN-1:AW+2];

  // A request is taken in IDLE, or in RESP so back-to-back requests see no bubble.
  assign accept = i_rst_n && i_data_req && (state != WAIT);

  core_mem_align u_align (
    .size     (i_data_mask),
    .lane     (i_data_addr[1:0]),
    .wr_data  (i_data_wr_data),
    .rd_word  (mem[idx]),
    .be       (be),
    .wr_word  (wr_word),
    .rd_data  (rd_data),
    .misalign (misalign)
  );

  // Sampled at acceptance, so a load right after a store sees the old word
  // only if issued before it; stores answer with zero.
  assign rsp_now = '{rd: i_data_wr_en ? 32'h0 : rd_data, err: misalign};

  // Storage is not reset; stores commit on the acceptance edge.
  always_ff @(posedge i_clk) begin
    if (accept && i_data_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      pend           <= '0;
      o_data_ack     <= 1'b0;
      o_data_err     <= 1'b0;
      o_data_rd_data <= '0;
    end else begin
      o_data_ack <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (i_data_req) begin
            if (LATENCY == 1) begin
              state          <= RESP;
              o_data_ack     <= 1'b1;
              o_data_rd_data <= rsp_now.rd;
              o_data_err     <= rsp_now.err;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
              pend  <= rsp_now;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            state          <= RESP;
            cnt            <= '0;
            o_data_ack     <= 1'b1;
            o_data_rd_data <= pend.rd;
            o_data_err     <= pend.err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_data_mem.sv
// Bench for core_data_mem: one LATENCY=1 and one LATENCY=3 instance, both
// DEPTH_WORDS=16, checked against a byte-addressed reference memory.
module tb_core_data_mem;
  import core_pkg::*;

  logic       clk;
  logic [1:0] rst_n, req, wr;
  logic [1:0][31:0] addr, wd;
  logic [1:0][1:0]  sz;
  logic ack0, ack1, err0, err1;
  logic [31:0] rd0, rd1;

  int n_chk = 0, n_err = 0;
  logic [7:0] mb [2][64];
  logic [31:0] exp_q [$];
  logic        eerr_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  core_data_mem #(.XLEN(32), .DEPTH_WORDS(16), .LATENCY(1), .INIT_FILE("")) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_data_req(req[0]), .i_data_addr(addr[0]),
    .i_data_wr_en(wr[0]), .i_data_mask(sz[0]), .i_data_wr_data(wd[0]),
    .o_data_ack(ack0), .o_data_rd_data(rd0), .o_data_err(err0));

  core_data_mem #(.XLEN(32), .DEPTH_WORDS(16), .LATENCY(3), .INIT_FILE("")) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_data_req(req[1]), .i_data_addr(addr[1]),
    .i_data_wr_en(wr[1]), .i_data_mask(sz[1]), .i_data_wr_data(wd[1]),
    .o_data_ack(ack1), .o_data_rd_data(rd1), .o_data_err(err1));

  function automatic logic g_ack(int d);  return d == 0 ? ack0 : ack1; endfunction
  function automatic logic g_err(int d);  return d == 0 ? err0 : err1; endfunction
  function automatic logic [31:0] g_rd(int d); return d == 0 ? rd0 : rd1; endfunction
  function automatic int lat(int d); return d == 0 ? 1 : 3; endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-byte memory per instance, address wraps modulo 64.
  task automatic model(int d, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] data);
    int o, n;
    logic [31:0] r;
    logic e;
    o = int'(a & 32'd63);
    n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    e = (s == 2'b11) || ((a % n) != 0);
    r = '0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        if (w) mb[d][o+i] = data[8*i +: 8];
        else   r[8*i +: 8] = mb[d][o+i];
      end
    end
    exp_q.push_back(r);
    eerr_q.push_back(e);
  endtask

  task automatic drv(int d, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] data);
    req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wd[d] = data;
  endtask

  task automatic chk_rsp(string tag, int d);
    chk({tag, "_rd"},  g_rd(d), exp_q.pop_front());
    chk({tag, "_err"}, 32'(g_err(d)), 32'(eerr_q.pop_front()));
  endtask

  // Single transaction: accept, then bounded wait for ack.
  task automatic xact(string tag, int d, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] data);
    int n;
    @(negedge clk);
    drv(d, w, s, a, data);
    model(d, w, s, a, data);
    @(posedge clk); #1;
    req[d] = 1'b0;
    n = 0;
    while (!g_ack(d) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat(d) - 1));
    chk_rsp(tag, d);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    rst_n = 2'b00; req = '0; wr = '0; sz = '0; addr = '0; wd = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(g_ack(d)), 32'h0);
      chk("rst_err", 32'(g_err(d)), 32'h0);
      chk("rst_rd",  g_rd(d), 32'h0);
    end
    rst_n = 2'b11;

    // Known contents before anything reads.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) xact("init", d, 1'b1, SIZE_W, 32'(w * 4), $urandom);

    // Back-to-back store/load, LATENCY=1.
    @(negedge clk);
    drv(0, 1'b1, SIZE_W, 32'h10, 32'hDEADBEEF); model(0, 1'b1, SIZE_W, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_ack0", 32'(ack0), 32'h1);
    chk_rsp("b2b_st", 0);
    drv(0, 1'b0, SIZE_W, 32'h10, 32'h0); model(0, 1'b0, SIZE_W, 32'h10, 32'h0);
    @(negedge clk);
    chk("b2b_ack1", 32'(ack0), 32'h1);
    chk("b2b_val", rd0, 32'hDEADBEEF);
    chk_rsp("b2b_ld", 0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_ack2", 32'(ack0), 32'h0);

    // Lanes and misalignment.
    xact("w", 0, 1'b1, SIZE_W, 32'h20, 32'h11223344);
    xact("b", 0, 1'b1, SIZE_B, 32'h22, 32'hFFFFFFAA);
    xact("h", 0, 1'b1, SIZE_H, 32'h20, 32'hFFFFBEEF);
    xact("lw", 0, 1'b0, SIZE_W, 32'h20, 32'h0);
    chk("lw_val", rd0, 32'h11AABEEF);
    xact("lb", 0, 1'b0, SIZE_B, 32'h23, 32'h0);
    chk("lb_val", rd0, 32'h00000011);
    xact("mis_h", 0, 1'b1, SIZE_H, 32'h21, 32'h12345678);
    chk("mis_h_err", 32'(err0), 32'h1);
    xact("lw2", 0, 1'b0, SIZE_W, 32'h20, 32'h0);
    chk("lw2_val", rd0, 32'h11AABEEF);
    xact("mis_w", 0, 1'b0, SIZE_W, 32'h22, 32'h0);
    chk("mis_w_err", 32'(err0), 32'h1);
    chk("mis_w_rd", rd0, 32'h0);
    xact("rsv", 0, 1'b0, 2'b11, 32'h20, 32'h0);
    chk("rsv_err", 32'(err0), 32'h1);

    // Aliasing: 0x40 wraps onto word 0 with 16 words.
    xact("al_st", 0, 1'b1, SIZE_W, 32'h40, 32'h1);
    xact("al_ld", 0, 1'b0, SIZE_W, 32'h00, 32'h0);
    chk("al_val", rd0, 32'h1);

    // LATENCY=3, req held high; fields scrambled while waiting.
    @(negedge clk);
    drv(1, 1'b1, SIZE_W, 32'h4, 32'h5); model(1, 1'b1, SIZE_W, 32'h4, 32'h5);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("hh_ack", 32'(ack1), 32'((k % 3) == 0));
      if ((k % 3) == 0) chk_rsp("hh", 1);
      if (k == 3) begin
        drv(1, 1'b0, SIZE_W, 32'h4, 32'h0); model(1, 1'b0, SIZE_W, 32'h4, 32'h0);
      end else if (k == 6) begin
        drv(1, 1'b0, SIZE_B, 32'h4, 32'h0); model(1, 1'b0, SIZE_B, 32'h4, 32'h0);
      end else if (k == 9) begin
        chk("hh_val", rd1, 32'h5);
        req[1] = 1'b0;
      end else begin
        drv(1, 1'b1, SIZE_W, 32'h4, 32'hFFFFFFFF);
      end
    end

    // Reset one cycle after accepting a store; a request during reset is ignored.
    @(negedge clk);
    drv(1, 1'b1, SIZE_W, 32'h8, 32'h77); model(1, 1'b1, SIZE_W, 32'h8, 32'h77);
    void'(exp_q.pop_back()); void'(eerr_q.pop_back());
    @(negedge clk);
    rst_n[1] = 1'b0;
    drv(1, 1'b1, SIZE_W, 32'h8, 32'hEE);
    repeat (2) begin
      @(negedge clk);
      chk("mr_ack_rst", 32'(ack1), 32'h0);
    end
    rst_n[1] = 1'b1;
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mr_ack", 32'(ack1), 32'h0);
      chk("mr_rd", rd1, 32'h0);
    end
    xact("mr_ld", 1, 1'b0, SIZE_W, 32'h8, 32'h0);
    chk("mr_val", rd1, 32'h77);

    // Random traffic on both instances, addresses alias over 0..255.
    for (int i = 0; i < 120; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 7) begin
        if (rs == SIZE_H) ra[0] = 1'b0;
        if (rs == SIZE_W) ra[1:0] = 2'b00;
      end
      xact("rnd", i % 2, 1'($urandom), rs, ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
